// File: rtl/ksa_if.sv
// Request/memory bundle between the sequencing controller, the ARC4 key-scheduling
// stage and the 256x8 S memory. The slave side is the ksa block itself.
interface ksa_if #(
   parameter int KEY_BYTES = 3
);
   logic                   en;
   logic                   rdy;
   logic [8*KEY_BYTES-1:0] key;
   logic [7:0]             addr;
   logic [7:0]             rddata;
   logic [7:0]             wrdata;
   logic                   wren;

   modport master (
      output en, key, rddata,
      input  rdy, addr, wrdata, wren
   );

   modport slave (
      input  en, key, rddata,
      output rdy, addr, wrdata, wren
   );
endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling stage operating on an external 256x8 S memory (1-cycle read latency).
// Optional macro KSA_SKIP_SELF_SWAP_EN: skip both writes of an iteration when j equals i.
module ksa #(
   parameter int KEY_BYTES = 3
) (
   input  logic  clk,
   input  logic  rst_n,
   ksa_if.slave  bus
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ_I  = 3'd1,
      LOAD_I  = 3'd2,
      READ_J  = 3'd3,
      LOAD_J  = 3'd4,
      WRITE_I = 3'd5,
      WRITE_J = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   state_t                 after_iter_s;
   logic [7:0]             i_q, i_d;
   logic [7:0]             j_q, j_d;
   logic [7:0]             si_q, si_d;
   logic [7:0]             sj_q, sj_d;
   logic [KW-1:0]          kidx_q, kidx_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic                   rdy_q, rdy_d;
   logic                   wren_q, wren_d;
   logic [7:0]             addr_q, addr_d;
   logic [7:0]             wrdata_q, wrdata_d;
   logic [7:0]             i_next_s;
   logic [KW-1:0]          kidx_next_s;

   // Byte idx of the latched key, byte 0 being the most significant one.
   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                           input logic [KW-1:0] idx);
      logic [7:0] b_sel;
      b_sel = 8'd0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         b_sel = (idx == KW'(b)) ? k[8*(KEY_BYTES-1-b) +: 8] : b_sel;
      end
      return b_sel;
   endfunction

   // Next-state, datapath update and registered-output decode.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      si_d        = si_q;
      sj_d        = sj_q;
      kidx_d      = kidx_q;
      key_d       = key_q;
      i_next_s    = i_q + 8'd1;
      kidx_next_s = (kidx_q == KW'(KEY_BYTES-1)) ? {KW{1'b0}} : kidx_q + KW'(1);
      after_iter_s = (i_q == 8'd255) ? IDLE : READ_I;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               key_d   = bus.key;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = {KW{1'b0}};
               state_d = READ_I;
            end else begin
               state_d = IDLE;
            end
         end
         READ_I:  state_d = LOAD_I;
         LOAD_I: begin
            si_d    = bus.rddata;
            j_d     = j_q + bus.rddata + key_byte(key_q, kidx_q);
            state_d = READ_J;
         end
         READ_J:  state_d = LOAD_J;
         LOAD_J: begin
            sj_d = bus.rddata;
`ifdef KSA_SKIP_SELF_SWAP_EN
            if (j_q == i_q) begin
               i_d     = i_next_s;
               kidx_d  = kidx_next_s;
               state_d = after_iter_s;
            end else begin
               state_d = WRITE_I;
            end
`else
            state_d = WRITE_I;
`endif
         end
         WRITE_I: state_d = WRITE_J;
         WRITE_J: begin
            i_d     = i_next_s;
            kidx_d  = kidx_next_s;
            state_d = after_iter_s;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      case (state_d)
         READ_I, WRITE_I: addr_d = i_d;
         READ_J, WRITE_J: addr_d = j_d;
         default:         addr_d = 8'd0;
      endcase

      case (state_d)
         WRITE_I: wrdata_d = sj_d;
         WRITE_J: wrdata_d = si_d;
         default: wrdata_d = 8'd0;
      endcase

      wren_d = (state_d == WRITE_I) || (state_d == WRITE_J);
      rdy_d  = (state_d == IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= IDLE;
         i_q      <= 8'd0;
         j_q      <= 8'd0;
         si_q     <= 8'd0;
         sj_q     <= 8'd0;
         kidx_q   <= {KW{1'b0}};
         key_q    <= {(8*KEY_BYTES){1'b0}};
         rdy_q    <= 1'b1;
         wren_q   <= 1'b0;
         addr_q   <= 8'd0;
         wrdata_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         si_q     <= si_d;
         sj_q     <= sj_d;
         kidx_q   <= kidx_d;
         key_q    <= key_d;
         rdy_q    <= rdy_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
      end
   end

   assign bus.rdy    = rdy_q;
   assign bus.wren   = wren_q;
   assign bus.addr   = addr_q;
   assign bus.wrdata = wrdata_q;

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: drives it against a 256x8 S memory model and compares
// against a software key schedule. Honours KSA_SKIP_SELF_SWAP_EN when defined.
module tb_ksa;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_init;
   logic [7:0] mem [256];

   always #5 clk = ~clk;

   ksa_if #(.KEY_BYTES(3)) bus ();

   ksa #(.KEY_BYTES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef KSA_SKIP_SELF_SWAP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   // S memory: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
      end else if (bus.wren === 1'b1) begin
         mem[bus.addr] <= bus.wrdata;
      end
      bus.rddata <= mem[bus.addr];
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_s [256];
   int exp_self;
   int run_cyc;
   int run_wr;
   logic [7:0] wa [$];
   logic [7:0] wd [$];

   task automatic model_ksa(input logic [23:0] k, input bit from_identity);
      logic [7:0]  j, t, kb;
      logic [23:0] kk;
      if (from_identity) begin
         for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
      end
      j = 8'd0;
      exp_self = 0;
      for (int i = 0; i < 256; i++) begin
         kk = k << (8 * (i % 3));
         kb = kk[23:16];
         j  = j + exp_s[i] + kb;
         if (j == 8'(i)) exp_self++;
         t        = exp_s[i];
         exp_s[i] = exp_s[j];
         exp_s[j] = t;
      end
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) n++;
      return n;
   endfunction

   function automatic int exp_cycles();
      return SKIP ? 1536 - 2 * exp_self : 1536;
   endfunction

   task automatic init_mem();
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
   endtask

   // Starts a run at the current negedge and follows it until rdy returns (bounded).
   task automatic run_ksa(input logic [23:0] k, input int poke_cyc,
                          input logic [23:0] poke_key, input int rst_cyc);
      wa.delete();
      wd.delete();
      run_cyc = 0;
      run_wr  = 0;
      bus.key = k;
      bus.en  = 1'b1;
      @(negedge clk);
      bus.en  = 1'b0;
      while (bus.rdy !== 1'b1 && run_cyc < 3000) begin
         if (bus.wren === 1'b1) begin
            run_wr++;
            wa.push_back(bus.addr);
            wd.push_back(bus.wrdata);
         end
         run_cyc++;
         bus.en = (run_cyc == poke_cyc);
         if (run_cyc == poke_cyc) bus.key = poke_key;
         rst_n = (run_cyc == rst_cyc);
         @(negedge clk);
      end
      bus.en = 1'b0;
      rst_n  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b1;
      bus.en   = 1'b0;
      bus.key  = 24'h000000;
      mem_init = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) begin
            rst_n    = 1'b0;
            mem_init = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (bus.rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy cycle %0d: got %b expected 1", c, bus.rdy);
         end
         checks++;
         if (bus.wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_wren cycle %0d: got %b expected 0", c, bus.wren);
         end
         checks++;
         if (bus.addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr cycle %0d: got %h expected 00", c, bus.addr);
         end
      end
   endtask

   task automatic test_key_zero();
      logic [7:0] ea [8];
      logic [7:0] ed [8];
      int nchk;
      if (SKIP) begin
         ea = '{8'd2, 8'd3, 8'd3, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
         ed = '{8'd3, 8'd2, 8'd5, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
         nchk = 4;
      end else begin
         ea = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd5};
         ed = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd2};
         nchk = 8;
      end
      init_mem();
      model_ksa(24'h000000, 1'b1);
      run_ksa(24'h000000, -1, 24'h000000, -1);
      for (int n = 0; n < nchk; n++) begin
         checks++;
         if (n >= wa.size() || wa[n] !== ea[n] || wd[n] !== ed[n]) begin
            errors++;
            $display("FAIL key0_write%0d: got addr %h data %h expected addr %h data %h",
                     n, wa[n], wd[n], ea[n], ed[n]);
         end
      end
      checks++;
      if (run_cyc !== exp_cycles()) begin
         errors++;
         $display("FAIL key0_cycles: got %0d expected %0d", run_cyc, exp_cycles());
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL key0_state: %0d bytes differ from model", mem_diffs());
      end
   endtask

   task automatic test_key_33c();
      init_mem();
      model_ksa(24'h00033C, 1'b1);
      run_ksa(24'h00033C, -1, 24'h000000, -1);
      checks++;
      if (run_cyc !== exp_cycles()) begin
         errors++;
         $display("FAIL k33c_cycles: got %0d expected %0d", run_cyc, exp_cycles());
      end
      checks++;
      if (run_wr !== (SKIP ? 512 - 2 * exp_self : 512)) begin
         errors++;
         $display("FAIL k33c_writes: got %0d expected %0d", run_wr,
                  SKIP ? 512 - 2 * exp_self : 512);
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL k33c_state: %0d bytes differ from model", mem_diffs());
      end
   endtask

   task automatic test_en_mid_run();
      init_mem();
      model_ksa(24'h00033C, 1'b1);
      run_ksa(24'h00033C, 500, 24'hFFFFFF, -1);
      checks++;
      if (run_cyc !== exp_cycles()) begin
         errors++;
         $display("FAIL midrun_en_cycles: got %0d expected %0d", run_cyc, exp_cycles());
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL midrun_en_state: %0d bytes differ from model", mem_diffs());
      end
   endtask

   task automatic test_mid_reset();
      init_mem();
      run_ksa(24'h00033C, -1, 24'h000000, 700);
      checks++;
      if (run_cyc !== 700) begin
         errors++;
         $display("FAIL midreset_cycles: got %0d expected 700", run_cyc);
      end
      checks++;
      if (bus.rdy !== 1'b1 || bus.wren !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: got rdy %b wren %b expected rdy 1 wren 0",
                  bus.rdy, bus.wren);
      end
      init_mem();
      model_ksa(24'hA51F07, 1'b1);
      run_ksa(24'hA51F07, -1, 24'h000000, -1);
      checks++;
      if (run_cyc !== exp_cycles()) begin
         errors++;
         $display("FAIL rerun_cycles: got %0d expected %0d", run_cyc, exp_cycles());
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL rerun_state: %0d bytes differ from model", mem_diffs());
      end
   endtask

   task automatic test_back_to_back();
      int d1;
      init_mem();
      model_ksa(24'h00033C, 1'b1);
      run_ksa(24'h00033C, -1, 24'h000000, -1);
      d1 = mem_diffs();
      run_ksa(24'h0A0B0C, -1, 24'h000000, -1);
      model_ksa(24'h0A0B0C, 1'b0);
      checks++;
      if (d1 != 0) begin
         errors++;
         $display("FAIL b2b_first_state: %0d bytes differ from model", d1);
      end
      checks++;
      if (run_cyc !== exp_cycles()) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d expected %0d", run_cyc, exp_cycles());
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL b2b_state: %0d bytes differ from model", mem_diffs());
      end
   endtask

   initial begin
      test_reset();
      test_key_zero();
      test_key_33c();
      test_en_mid_run();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
